// File: rtl/ram_hs_nx8_if.sv
// Request/response bundle for ram_hs_nx8: MOV/MOC handshake plus the sized access fields.
interface ram_hs_nx8_if #(
   parameter int unsigned ADDR_W = 9
);
   logic              MOV;
   logic              RW;
   logic [1:0]        Size;
   logic              SignExt;
   logic [ADDR_W-1:0] Address;
   logic [31:0]       DataIn;
   logic [31:0]       DataOut;
   logic              MOC;
   logic              ERR;

   modport master (
      output MOV, RW, Size, SignExt, Address, DataIn,
      input  DataOut, MOC, ERR
   );
   modport slave (
      input  MOV, RW, Size, SignExt, Address, DataIn,
      output DataOut, MOC, ERR
   );
endinterface

// File: rtl/ram_hs_nx8.sv
// Byte-addressed big-endian data memory with MOV/MOC handshake and programmable wait states.
// Define RAM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses instead of aligning them.
module ram_hs_nx8 #(
   parameter int unsigned DEPTH       = 512,
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic         clk,
   input logic         reset,
   ram_hs_nx8_if.slave bus
);
   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SumW = ADDR_W + 2;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              accept, complete;

   logic              rw_q, sext_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       dout_q;
   logic              err_q;

   // Not reset, so contents survive reset and can be preloaded.
   logic [7:0]        Mem [0:DEPTH-1];

   logic [2:0]        nbytes;
   logic [ADDR_W-1:0] base;
   logic [SumW-1:0]   last;
   logic              misalign, req_err, mem_we;
   logic [IdxW-1:0]   idx   [4];
   logic [7:0]        wbyte [4];
   logic [7:0]        rbyte [4];
   logic [31:0]       rdata;

   always_comb begin
      nbytes   = 3'd4;
      misalign = 1'b0;
      base     = addr_q;
      case (size_q)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
`ifdef RAM_ALIGN_CHECK_EN
      misalign = ((nbytes == 3'd2) && addr_q[0]) ||
                 ((nbytes == 3'd4) && (addr_q[1:0] != 2'b00));
`else
      if (nbytes == 3'd2) base[0] = 1'b0;
      if (nbytes == 3'd4) base[1:0] = 2'b00;
`endif
      // Range is judged on the requested address, before any forced alignment.
      last    = SumW'(addr_q) + SumW'(nbytes) - SumW'(1);
      req_err = misalign || (last >= SumW'(DEPTH));
   end

   // Byte k is at base+k; byte 0 is the most significant.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         idx[k]   = IdxW'(SumW'(base) + SumW'(k));
         rbyte[k] = Mem[idx[k]];
         wbyte[k] = 8'h00;
      end
      case (nbytes)
         3'd1: begin
            wbyte[0] = wdata_q[7:0];
            rdata    = {{24{sext_q & rbyte[0][7]}}, rbyte[0]};
         end
         3'd2: begin
            wbyte[0] = wdata_q[15:8];
            wbyte[1] = wdata_q[7:0];
            rdata    = {{16{sext_q & rbyte[0][7]}}, rbyte[0], rbyte[1]};
         end
         default: begin
            wbyte[0] = wdata_q[31:24];
            wbyte[1] = wdata_q[23:16];
            wbyte[2] = wdata_q[15:8];
            wbyte[3] = wdata_q[7:0];
            rdata    = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      complete = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.MOV) begin
               accept  = 1'b1;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) begin
               complete = 1'b1;
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            if (!bus.MOV) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rw_q    <= 1'b0;
         sext_q  <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         dout_q  <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rw_q    <= bus.RW;
            sext_q  <= bus.SignExt;
            size_q  <= bus.Size;
            addr_q  <= bus.Address;
            wdata_q <= bus.DataIn;
            err_q   <= 1'b0;
         end
         if (complete) begin
            err_q <= req_err;
            if (!req_err && rw_q) dout_q <= rdata;
         end
      end
   end

   // complete is only possible in StBusy, so an asserted reset also blocks the write.
   assign mem_we = complete && !req_err && !rw_q;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (3'(k) < nbytes) Mem[idx[k]] <= wbyte[k];
         end
      end
   end

   assign bus.DataOut = dout_q;
   assign bus.MOC     = (state_q == StDone);
   assign bus.ERR     = err_q;
endmodule

// File: tb/tb_ram_hs_nx8.sv
// Scoreboard bench for ram_hs_nx8: random sized accesses checked against a byte-array model.
module tb_ram_hs_nx8;
   localparam int unsigned DEPTH  = 512;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned WAIT   = 2;

   logic clk;
   logic reset;

   ram_hs_nx8_if #(.ADDR_W(ADDR_W)) bus ();

   ram_hs_nx8 #(
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .WAIT_CYCLES(WAIT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] dout;
      logic        err;
      int unsigned accept;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int unsigned edge_cnt = 0;
   logic [7:0]  model_mem [DEPTH];
   logic [31:0] model_dout = 32'h0;
   logic        moc_prev = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Reference: plain arithmetic over a byte array, MSB at the lowest address.
   function automatic void model(input bit rw, input bit [1:0] size, input bit sext,
                                 input int addr, input bit [31:0] wdata, output bit err);
      int     n;
      int     base;
      bit     mis;
      longint v;
      n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      base = addr;
      mis  = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
      mis = (addr % n) != 0;
`else
      base = addr - (addr % n);
`endif
      err = mis || (addr + n - 1 >= int'(DEPTH));
      if (err) return;
      if (rw) begin
         v = 0;
         for (int k = 0; k < n; k++) v = v * 256 + longint'(model_mem[base + k]);
         if (sext && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
         model_dout = v[31:0];
      end else begin
         for (int k = 0; k < n; k++) model_mem[base + k] = 8'((wdata >> (8 * (n - 1 - k))) & 32'hff);
      end
   endfunction

   task automatic access(input bit rw, input bit [1:0] size, input bit sext, input int addr,
                         input bit [31:0] wdata, input int hold);
      bit   err;
      exp_t e;
      int   n;
      @(posedge clk); #1;
      bus.MOV     = 1'b1;
      bus.RW      = rw;
      bus.Size    = size;
      bus.SignExt = sext;
      bus.Address = ADDR_W'(addr);
      bus.DataIn  = wdata;
      model(rw, size, sext, addr, wdata, err);
      e.dout   = model_dout;
      e.err    = err;
      e.accept = edge_cnt + 1;
      sbq.push_back(e);
      @(posedge clk); #1;
      // Request is latched; scramble the fields to show they are ignored now.
      bus.RW      = 1'($urandom);
      bus.Size    = 2'($urandom);
      bus.SignExt = 1'($urandom);
      bus.Address = ADDR_W'($urandom);
      bus.DataIn  = $urandom;
      n = 0;
      while (!bus.MOC && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("moc_timeout", 32'(bus.MOC), 32'd1);
      repeat (hold) begin
         @(posedge clk); #1;
         check("moc_hold", 32'(bus.MOC), 32'd1);
      end
      bus.MOV = 1'b0;
      @(posedge clk); #1;
      check("moc_drop", 32'(bus.MOC), 32'd0);
   endtask

   always @(negedge clk) begin
      if (reset && bus.MOC && !moc_prev) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_moc: got MOC rise with empty queue want none");
         end else begin
            mon_e = sbq.pop_front();
            check("latency", edge_cnt - mon_e.accept, WAIT + 1);
            check("dataout", bus.DataOut, mon_e.dout);
            check("err", 32'(bus.ERR), 32'(mon_e.err));
         end
      end
      moc_prev <= bus.MOC;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int addr;
      int nd;
      int first;
      reset       = 1'b0;
      bus.MOV     = 1'b0;
      bus.RW      = 1'b1;
      bus.Size    = 2'b00;
      bus.SignExt = 1'b0;
      bus.Address = '0;
      bus.DataIn  = 32'h0;
      #12;
      check("rst_moc", 32'(bus.MOC), 32'd0);
      check("rst_err", 32'(bus.ERR), 32'd0);
      check("rst_dout", bus.DataOut, 32'h0);
      #5 reset = 1'b1;

      for (int a = 0; a < int'(DEPTH); a += 4) access(1'b0, 2'b10, 1'b0, a, $urandom, 0);

      access(1'b0, 2'b10, 1'b0, 4, 32'h12345678, 0);
      access(1'b1, 2'b10, 1'b0, 4, 32'h0, 1);
      access(1'b0, 2'b00, 1'b0, 5, 32'h00000080, 0);
      access(1'b1, 2'b00, 1'b1, 5, 32'h0, 0);
      access(1'b1, 2'b00, 1'b0, 5, 32'h0, 0);
      access(1'b0, 2'b01, 1'b0, 4, 32'h00008001, 0);
      access(1'b1, 2'b01, 1'b1, 4, 32'h0, 0);
      access(1'b1, 2'b01, 1'b0, 4, 32'h0, 2);
      access(1'b0, 2'b01, 1'b0, 16, 32'hAAAABEEF, 0);
      access(1'b1, 2'b10, 1'b0, 16, 32'h0, 0);
      access(1'b1, 2'b00, 1'b0, 15, 32'h0, 0);
      access(1'b1, 2'b10, 1'b0, 6, 32'h0, 0);
      access(1'b0, 2'b10, 1'b0, 6, 32'hCAFEF00D, 0);
      access(1'b1, 2'b10, 1'b0, 4, 32'h0, 0);
      access(1'b1, 2'b10, 1'b0, 8, 32'h0, 0);
      access(1'b1, 2'b10, 1'b0, 510, 32'h0, 0);
      access(1'b0, 2'b00, 1'b0, 600, 32'h55, 0);
      access(1'b1, 2'b00, 1'b1, 511, 32'h0, 0);
      access(1'b1, 2'b11, 1'b1, 8, 32'h0, 0);
      access(1'b0, 2'b01, 1'b0, 511, 32'h1234, 0);

      repeat (300) begin
         addr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1023))
                                             : int'($urandom_range(0, DEPTH - 1));
         access(1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom,
                int'($urandom_range(0, 2)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      // Abort a word write mid-wait with an asynchronous reset.
      access(1'b0, 2'b10, 1'b0, 0, 32'h11223344, 0);
      access(1'b1, 2'b10, 1'b0, 0, 32'h0, 0);
      @(posedge clk); #1;
      bus.MOV     = 1'b1;
      bus.RW      = 1'b0;
      bus.Size    = 2'b10;
      bus.SignExt = 1'b0;
      bus.Address = '0;
      bus.DataIn  = 32'hDEADBEEF;
      @(posedge clk);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("abort_moc", 32'(bus.MOC), 32'd0);
      check("abort_err", 32'(bus.ERR), 32'd0);
      check("abort_dout", bus.DataOut, 32'h0);
      bus.MOV    = 1'b0;
      model_dout = 32'h0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      for (int k = 0; k < 4; k++) check("abort_mem", 32'(dut.Mem[k]), 32'(model_mem[k]));
      access(1'b1, 2'b10, 1'b0, 0, 32'h0, 0);

      nd    = 0;
      first = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (dut.Mem[i] !== model_mem[i]) begin
            if (nd == 0) first = i;
            nd++;
         end
      end
      total++;
      if (nd != 0) begin
         bad++;
         $display("FAIL mem_sweep: got %0d differing bytes (first @%0d = %h) want %h",
                  nd, first, dut.Mem[first], model_mem[first]);
      end
      check("queue_empty", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram_hs_nx8.md
# ram_hs_nx8

Parametrised byte-addressed, big-endian data memory with the MOV/MOC memory handshake and a programmable wait-state counter. It is the successor to the fixed 512x8 RAM attached to the MIPS DataPath, which it replaces. It adds configurable depth, configurable access latency, explicit byte/halfword/word sizing with sign extension, and an error flag for misaligned or out-of-range accesses.

## Interface
Parameters:
- DEPTH, 512: number of bytes stored.
- ADDR_W, 9: address width; DEPTH <= 2**ADDR_W is required.
- WAIT_CYCLES, 2: extra cycles between request accept and MOC; range 0..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MOV  in  1  memory operation valid (request).
- RW  in  1  1 = read, 0 = write.
- Size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is reserved and treated as word.
- SignExt  in  1  read sign-extension (1 = lb/lh, 0 = lbu/lhu); ignored for words and writes.
- Address  in  ADDR_W  byte address.
- DataIn  in  32  write data, taken from the low bytes (byte: [7:0], half: [15:0]).
- DataOut  out  32  read data, right-justified and extended.
- MOC  out  1  memory operation complete.
- ERR  out  1  access rejected; valid while MOC=1.

## Operation
- Storage is reg [7:0] Mem[0:DEPTH-1]. Contents are not cleared by reset, so the bench can preload them hierarchically.
- The block is big-endian: the MSB lives at Address and the LSB at Address+size-1.
- The FSM has three states:
  - IDLE: MOC=0. When MOV=1 is sampled, RW, Size, SignExt, Address and DataIn are latched, the counter is loaded with WAIT_CYCLES, and the FSM goes to BUSY.
  - BUSY: the counter decrements each cycle. When it is 0, the access is performed and the FSM goes to DONE with MOC=1.
  - DONE: MOC holds at 1. When MOV=0 is sampled, the FSM returns to IDLE and MOC drops.
- Inputs are ignored outside IDLE. Only the latched request is used.
- Reads load DataOut with the sized value:
  - Byte: extended with bit 7 if SignExt=1, else zero-extended.
  - Halfword: extended with bit 15 if SignExt=1, else zero-extended.
  - Word: all 32 bits unchanged.
- Writes update only the addressed bytes. DataOut is unchanged on writes.
- An error access sets ERR=1, leaves memory unmodified and leaves DataOut unchanged. It still completes the full handshake with the same latency. An access is an error when:
  - the last byte (Address+size-1) is >= DEPTH, or
  - it is misaligned (see Configuration).
- ERR clears when the next request is accepted.

## Timing
- Reset values: MOC=0, ERR=0, DataOut=32'h0, FSM=IDLE, counter=0.
- Accept happens at edge E0. MOC rises at edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives MOC one edge after accept.
- Memory write and DataOut update occur at the same edge on which MOC rises.
- If MOV is already low when MOC rises, MOC falls at the next edge. Otherwise MOC falls one edge after MOV is sampled low.
- The minimum request-to-request period is WAIT_CYCLES+3 cycles.
- MOV held high after MOC does not start a second access. The master must drop MOV.
- Reset asserted mid-access:
  - It takes effect immediately (asynchronously) and aborts the access.
  - A write not yet committed never reaches memory.
  - Outputs return to their reset values.
- The counter is 4 bits. WAIT_CYCLES values above 15 are illegal.

## Configuration
- RAM_ALIGN_CHECK_EN defined: halfword accesses with Address[0]≠0, or word accesses with Address[1:0]≠0, are errors (ERR=1, no access).
- RAM_ALIGN_CHECK_EN undefined:
  - No alignment check; the low address bits are forced to zero for the access (halfword clears bit 0, word clears bits 1:0).
  - ERR is raised only for out-of-range accesses.

## Test plan
- Word read, WAIT_CYCLES=2, with Mem[4..7]=12,34,56,78 (hex): read word @4 -> MOC high exactly 3 edges after accept, DataOut=32'h12345678, ERR=0; drop MOV -> MOC=0 next edge.
- Sized reads with Mem[5]=8'h80: lb @5 -> 32'hFFFFFF80; lbu @5 -> 32'h00000080; lh @4 with Mem[4..5]=80,01 -> 32'hFFFF8001; lhu -> 32'h00008001.
- Halfword write: sh DataIn=32'hAAAABEEF @16 -> Mem[16]=BE, Mem[17]=EF, Mem[15] and Mem[18] unchanged; lw @16 then returns 32'hBEEF, followed by the prior contents of Mem[18..19].
- Misaligned word, macro defined: lw @6 -> ERR=1, MOC after the normal latency, DataOut unchanged. sw @6 -> Mem[4..9] unchanged. Macro undefined: lw @6 returns the word at 4 with ERR=0.
- Out of range, DEPTH=512, ADDR_W=10: lw @510 and sb @600 -> ERR=1 and memory unchanged; lb @511 -> ERR=0.
- Reset during BUSY of sw @0 with DataIn=32'hDEADBEEF (WAIT_CYCLES=4, reset low at cycle 2) -> MOC=0 immediately, Mem[0..3] unchanged; a later fresh request completes normally.
